// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequences a 16-word local program store and issues data ops
// to the execute pipeline, handling jump, nop and halt control words.
module instr_fetch_unit #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic [3:0] load_addr,
    input  logic [7:0] load_data,
    input  logic       start,
    input  logic       stall,
    output logic [7:0] instr,
    output logic       instr_valid,
    output logic [3:0] pc,
    output logic       done,
    output logic [7:0] fetch_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state, state_n;
    logic [7:0] store [DEPTH];
    logic [7:0] w, instr_n, fetch_count_n;
    logic [3:0] pc_n;
    logic       instr_valid_n, done_n;

    assign w = store[pc];

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_n       = instr;
        instr_valid_n = instr_valid;
        done_n        = done;
        fetch_count_n = fetch_count;
        if (state == RUN) begin
            if (!stall) begin
                if (w[7:6] != 2'b11) begin
                    instr_n       = w;
                    instr_valid_n = 1'b1;
                    pc_n          = pc + 4'd1;
                    fetch_count_n = (fetch_count == 8'hFF) ? fetch_count : fetch_count + 8'd1;
                end else begin
                    // control words never reach the execute pipeline
                    instr_n       = 8'h00;
                    instr_valid_n = 1'b0;
                    pc_n          = (w[5:4] == 2'b00) ? w[3:0] : (w[5:4] == 2'b11) ? pc : pc + 4'd1;
                    state_n       = (w[5:4] == 2'b11) ? HALT : RUN;
                    done_n        = (w[5:4] == 2'b11);
                end
            end
        end else begin
            instr_valid_n = 1'b0;
            if (start) begin
                state_n       = RUN;
                pc_n          = 4'd0;
                done_n        = 1'b0;
                fetch_count_n = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= 4'd0;
            instr       <= 8'h00;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            fetch_count <= 8'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_valid <= instr_valid_n;
            done        <= done_n;
            fetch_count <= fetch_count_n;
        end
    end

    // store is not reset so it can map onto plain RAM
    always_ff @(posedge clk) begin
        if (!rst && load_en && state != RUN)
            store[load_addr] <= load_data;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus random stimulus checked against
// a behavioural program-interpreter model.
module tb_instr_fetch_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0, load_en = 1'b0, start = 1'b0, stall = 1'b0;
    logic [3:0] load_addr = 4'd0;
    logic [7:0] load_data = 8'd0;
    logic [7:0] instr, fetch_count;
    logic       instr_valid, done;
    logic [3:0] pc;

    int vectors = 0, miscompares = 0;
    int m_mem [16];
    int m_mode = 0;
    int m_pc = 0, m_instr = 0, m_valid = 0, m_done = 0, m_cnt = 0;

    instr_fetch_unit #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stall(stall), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .done(done), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode: 0 idle, 1 running, 2 halted
    task automatic model_edge();
        int wd, op, sub;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_instr = 0; m_valid = 0; m_done = 0; m_cnt = 0;
        end else if (m_mode == 1) begin
            if (!stall) begin
                wd = m_mem[m_pc]; op = wd / 64; sub = (wd / 16) % 4;
                if (op < 3) begin
                    m_instr = wd; m_valid = 1; m_pc = (m_pc + 1) % 16;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                end else begin
                    m_instr = 0; m_valid = 0;
                    if (sub == 0) m_pc = wd % 16;
                    else if (sub == 3) begin m_mode = 2; m_done = 1; end
                    else m_pc = (m_pc + 1) % 16;
                end
            end
        end else begin
            if (load_en) m_mem[load_addr] = load_data;
            m_valid = 0;
            if (start) begin m_mode = 1; m_pc = 0; m_done = 0; m_cnt = 0; end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("instr", instr, m_instr);
        check("valid", instr_valid, m_valid);
        check("pc", pc, m_pc);
        check("done", done, m_done);
        check("count", fetch_count, m_cnt);
    endtask

    task automatic load(input int a, input int d);
        load_en = 1'b1; load_addr = a[3:0]; load_data = d[7:0];
        cyc();
        load_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    function automatic int data_word();
        return $urandom_range(0, 191);
    endfunction

    function automatic int rand_word();
        return ($urandom_range(0, 7) < 5) ? data_word() : 192 + $urandom_range(0, 63);
    endfunction

    initial begin
        do_reset();
        check("rst_pc", pc, 0);
        check("rst_valid", instr_valid, 0);
        // linear run
        for (int a = 0; a < 16; a++) load(a, 8'hF0);
        load(0, 8'h14); load(1, 8'h58); load(2, 8'hF0);
        go(); run(4);
        check("lin_done", done, 1);
        check("lin_cnt", fetch_count, 2);
        check("lin_pc", pc, 2);
        // jump from 15 back to 3 after a full data sweep
        for (int a = 0; a < 15; a++) load(a, data_word());
        load(15, 8'hC3);
        go(); run(16);
        check("jmp_pc", pc, 3);
        check("jmp_bubble", instr_valid, 0);
        check("jmp_cnt", fetch_count, 15);
        run(5);
        do_reset();
        load(3, 8'hF0);
        go(); run(5);
        check("jmp_halt", done, 1);
        check("jmp_halt_cnt", fetch_count, 3);
        // stall mid-run with an ignored write to address 5
        for (int a = 0; a < 10; a++) load(a, data_word());
        load(5, 8'h21); load(10, 8'hF0);
        go(); run(3);
        load_en = 1'b1; load_addr = 4'd5; load_data = 8'hAA; stall = 1'b1;
        run(3);
        load_en = 1'b0; stall = 1'b0;
        run(10);
        check("stall_done", done, 1);
        check("stall_cnt", fetch_count, 10);
        // reset mid-run then rerun
        go(); run(4);
        check("mid_cnt", fetch_count, 4);
        do_reset();
        check("mid_rst_cnt", fetch_count, 0);
        go(); run(12);
        check("rerun_cnt", fetch_count, 10);
        // saturation: an all-data program wraps forever
        for (int a = 0; a < 16; a++) load(a, data_word());
        go(); run(300);
        check("sat_cnt", fetch_count, 255);
        // random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            load_en = ($urandom_range(0, 3) == 0);
            load_addr = 4'($urandom_range(0, 15));
            load_data = 8'(rand_word());
            start = ($urandom_range(0, 15) == 0);
            stall = ($urandom_range(0, 3) == 0);
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
